// File: rtl/regfile_sb.sv
// Two-read / two-write register file with a per-register busy scoreboard.
// Optional same-cycle write forwarding and an optional hardwired zero register.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_stall
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    logic wr0_ok;
    logic wr1_ok;
    logic issue_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Writes and issues aimed at the hardwired zero register are dropped here,
    // so nothing downstream needs to special-case address 0.
    assign wr0_ok      = wr0_en && !is_zero(wr0_addr);
    assign wr1_ok      = wr1_en && !is_zero(wr1_addr);
    assign issue_stall = issue_en && busy[issue_addr];
    assign issue_ok    = issue_en && !busy[issue_addr] && !is_zero(issue_addr);

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_busy_a = busy[rd_addr_a];
        if (BYPASS != 0) begin
            if (wr1_ok && (wr1_addr == rd_addr_a)) begin
                rd_data_a = wr1_data;
            end else if (wr0_ok && (wr0_addr == rd_addr_a)) begin
                rd_data_a = wr0_data;
            end
            if (((wr0_ok && (wr0_addr == rd_addr_a)) || (wr1_ok && (wr1_addr == rd_addr_a)))
                && !(issue_ok && (issue_addr == rd_addr_a))) begin
                rd_busy_a = 1'b0;
            end
        end
        if (is_zero(rd_addr_a)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        rd_busy_b = busy[rd_addr_b];
        if (BYPASS != 0) begin
            if (wr1_ok && (wr1_addr == rd_addr_b)) begin
                rd_data_b = wr1_data;
            end else if (wr0_ok && (wr0_addr == rd_addr_b)) begin
                rd_data_b = wr0_data;
            end
            if (((wr0_ok && (wr0_addr == rd_addr_b)) || (wr1_ok && (wr1_addr == rd_addr_b)))
                && !(issue_ok && (issue_addr == rd_addr_b))) begin
                rd_busy_b = 1'b0;
            end
        end
        if (is_zero(rd_addr_b)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end
    end

    // Writes clear busy first so that an issue on the same edge sets it again.
    always_comb begin
        busy_next = busy;
        if (wr0_ok) busy_next[wr0_addr] = 1'b0;
        if (wr1_ok) busy_next[wr1_addr] = 1'b0;
        if (issue_ok) busy_next[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            // Port 1 is assigned last so it wins a same-address collision.
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one forwarding instance and one non-forwarding
// instance share every input so their outputs can be compared against fixed values.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b, rd_data_a_nb, rd_data_b_nb;
    logic              rd_busy_a, rd_busy_b, rd_busy_a_nb, rd_busy_b_nb;
    logic              wr0_en, wr1_en, issue_en;
    logic [ADDR_W-1:0] wr0_addr, wr1_addr, issue_addr;
    logic [DATA_W-1:0] wr0_data, wr1_data;
    logic              issue_stall, issue_stall_nb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_stall(issue_stall)
    );

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a_nb), .rd_data_b(rd_data_b_nb),
        .rd_busy_a(rd_busy_a_nb), .rd_busy_b(rd_busy_b_nb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_stall(issue_stall_nb)
    );

    task automatic idle();
        reset    = 1'b0;
        wr0_en   = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en   = 1'b0; wr1_addr = '0; wr1_data = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        issue_en = 1'b1; issue_addr = 5'd6;
        step();
        idle();
        rd_addr_a = 5'd5; rd_addr_b = 5'd6;
        #1;
        checks++;
        if (rd_data_a !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL pre_reset_data: got %h expected %h", rd_data_a, 32'hDEADBEEF);
        end
        checks++;
        if (rd_busy_b !== 1'b1) begin
            errors++; $display("[TB] FAIL pre_reset_busy: got %b expected 1", rd_busy_b);
        end
        reset = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'h77;
        step();
        idle();
        rd_addr_a = 5'd5; rd_addr_b = 5'd6;
        #1;
        checks++;
        if (rd_data_a !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_data_r5: got %h expected 0", rd_data_a);
        end
        checks++;
        if (rd_busy_a !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy_r5: got %b expected 0", rd_busy_a);
        end
        checks++;
        if (rd_busy_b !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy_r6: got %b expected 0", rd_busy_b);
        end
        rd_addr_a = 5'd8;
        issue_en = 1'b1; issue_addr = 5'd6;
        #1;
        checks++;
        if (rd_data_a_nb !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_drops_write: got %h expected 0", rd_data_a_nb);
        end
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_stall: got %b expected 0", issue_stall);
        end
        idle();
    endtask

    task automatic test_dual_write();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        rd_addr_a = 5'd7;
        #1;
        checks++;
        if (rd_data_a !== 32'h22) begin
            errors++; $display("[TB] FAIL dual_bypass: got %h expected %h", rd_data_a, 32'h22);
        end
        checks++;
        if (rd_data_a_nb !== 32'h0) begin
            errors++; $display("[TB] FAIL dual_nobypass_old: got %h expected 0", rd_data_a_nb);
        end
        step();
        idle();
        rd_addr_a = 5'd7;
        #1;
        checks++;
        if (rd_data_a !== 32'h22) begin
            errors++; $display("[TB] FAIL dual_stored: got %h expected %h", rd_data_a, 32'h22);
        end
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h33;
        rd_addr_b = 5'd10;
        #1;
        checks++;
        if (rd_data_b !== 32'h33) begin
            errors++; $display("[TB] FAIL wr0_bypass: got %h expected %h", rd_data_b, 32'h33);
        end
        step();
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        issue_en = 1'b1; issue_addr = 5'd3;
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL first_issue_stall: got %b expected 0", issue_stall);
        end
        step();
        rd_addr_b = 5'd3;
        #1;
        checks++;
        if (rd_busy_b !== 1'b1) begin
            errors++; $display("[TB] FAIL issued_busy: got %b expected 1", rd_busy_b);
        end
        checks++;
        if (issue_stall !== 1'b1) begin
            errors++; $display("[TB] FAIL second_issue_stall: got %b expected 1", issue_stall);
        end
        step();
        checks++;
        if (issue_stall !== 1'b1) begin
            errors++; $display("[TB] FAIL held_issue_stall: got %b expected 1", issue_stall);
        end
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h5;
        #1;
        checks++;
        if (rd_busy_b !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_bypass_clear: got %b expected 0", rd_busy_b);
        end
        checks++;
        if (rd_busy_b_nb !== 1'b1) begin
            errors++; $display("[TB] FAIL busy_nobypass_held: got %b expected 1", rd_busy_b_nb);
        end
        step();
        wr0_en = 1'b0;
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_released: got %b expected 0", issue_stall);
        end
        checks++;
        if (rd_data_b !== 32'h5) begin
            errors++; $display("[TB] FAIL r3_written: got %h expected %h", rd_data_b, 32'h5);
        end
        step();
        idle();
        rd_addr_b = 5'd3;
        #1;
        checks++;
        if (rd_busy_b !== 1'b1) begin
            errors++; $display("[TB] FAIL held_issue_accepted: got %b expected 1", rd_busy_b);
        end
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h6;
        step();
        idle();
        rd_addr_b = 5'd3;
        #1;
        checks++;
        if (rd_busy_b !== 1'b0) begin
            errors++; $display("[TB] FAIL wr1_clears_busy: got %b expected 0", rd_busy_b);
        end
    endtask

    task automatic test_simultaneous();
        idle();
        issue_en = 1'b1; issue_addr = 5'd9;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hA;
        rd_addr_a = 5'd9;
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL simul_stall: got %b expected 0", issue_stall);
        end
        step();
        idle();
        rd_addr_a = 5'd9;
        #1;
        checks++;
        if (rd_data_a !== 32'hA) begin
            errors++; $display("[TB] FAIL simul_data: got %h expected %h", rd_data_a, 32'hA);
        end
        checks++;
        if (rd_busy_a !== 1'b1) begin
            errors++; $display("[TB] FAIL simul_busy: got %b expected 1", rd_busy_a);
        end
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hA;
        step();
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        #1;
        checks++;
        if (rd_data_a !== 32'h0) begin
            errors++; $display("[TB] FAIL zero_bypass: got %h expected 0", rd_data_a);
        end
        step();
        wr0_en = 1'b0; wr1_en = 1'b0;
        #1;
        checks++;
        if (rd_data_b_nb !== 32'h0) begin
            errors++; $display("[TB] FAIL zero_stored: got %h expected 0", rd_data_b_nb);
        end
        checks++;
        if (rd_busy_a !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_busy: got %b expected 0", rd_busy_a);
        end
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_stall: got %b expected 0", issue_stall);
        end
        idle();
    endtask

    task automatic test_bypass_off();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h1111;
        step();
        idle();
        wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h1234;
        rd_addr_a = 5'd4;
        #1;
        checks++;
        if (rd_data_a_nb !== 32'h1111) begin
            errors++; $display("[TB] FAIL nobypass_old: got %h expected %h", rd_data_a_nb, 32'h1111);
        end
        checks++;
        if (rd_data_a !== 32'h1234) begin
            errors++; $display("[TB] FAIL bypass_new: got %h expected %h", rd_data_a, 32'h1234);
        end
        step();
        idle();
        rd_addr_a = 5'd4;
        #1;
        checks++;
        if (rd_data_a_nb !== 32'h1234) begin
            errors++; $display("[TB] FAIL nobypass_after: got %h expected %h", rd_data_a_nb, 32'h1234);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'hAAAA;
        wr1_en = 1'b1; wr1_addr = 5'd31; wr1_data = 32'hBBBB;
        step();
        wr0_data = 32'hCCCC;
        wr1_en = 1'b0;
        step();
        idle();
        rd_addr_a = 5'd12; rd_addr_b = 5'd31;
        #1;
        checks++;
        if (rd_data_a !== 32'hCCCC) begin
            errors++; $display("[TB] FAIL b2b_r12: got %h expected %h", rd_data_a, 32'hCCCC);
        end
        checks++;
        if (rd_data_b !== 32'hBBBB) begin
            errors++; $display("[TB] FAIL b2b_r31: got %h expected %h", rd_data_b, 32'hBBBB);
        end
    endtask

    initial begin
        idle();
        rd_addr_a = '0; rd_addr_b = '0;
        reset = 1'b1;
        step();
        step();
        idle();
        test_reset();
        test_dual_write();
        test_scoreboard();
        test_simultaneous();
        test_zero_reg();
        test_bypass_off();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
